// File: rtl/chromosome_pool.sv
// Population store for the GA processor: COUNT chromosome/fitness entries, one write
// port, two registered read ports, sequenced clear, occupancy and optional elite register
// (CHROMOSOME_POOL_BEST_TRACK_EN).
module chromosome_pool #(
    parameter  int COUNT      = 32,
    parameter  int DATA_WIDTH = 19,
    parameter  int FIT_WIDTH  = 64,
    localparam int ADDR_WIDTH = $clog2(COUNT),
    localparam int OCC_WIDTH  = $clog2(COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [FIT_WIDTH-1:0]  wr_fit,

    input  logic                  rd_a_en,
    input  logic [ADDR_WIDTH-1:0] rd_a_addr,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    output logic [FIT_WIDTH-1:0]  rd_a_fit,
    output logic                  rd_a_ok,
    output logic                  rd_a_vld,

    input  logic                  rd_b_en,
    input  logic [ADDR_WIDTH-1:0] rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    output logic [FIT_WIDTH-1:0]  rd_b_fit,
    output logic                  rd_b_ok,
    output logic                  rd_b_vld,

    input  logic                  clr_start,
    output logic                  busy,
    output logic [OCC_WIDTH-1:0]  occupancy,

    output logic [DATA_WIDTH-1:0] best_data,
    output logic [FIT_WIDTH-1:0]  best_fit,
    output logic                  best_valid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [COUNT-1:0]        valid;

    logic [DATA_WIDTH-1:0]   mem_data [COUNT];
    logic [FIT_WIDTH-1:0]    mem_fit  [COUNT];

    logic                    clr_go;
    logic                    wr_accept;
    logic                    rd_a_hit;
    logic                    rd_b_hit;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr) < COUNT;
    endfunction

    // A clear request wins over a write issued in the same cycle.
    assign clr_go    = (state == S_IDLE) && clr_start;
    assign wr_accept = (state == S_IDLE) && !clr_start && wr_en && in_range(wr_addr);
    assign rd_a_hit  = (state == S_IDLE) && in_range(rd_a_addr) && valid[rd_a_addr];
    assign rd_b_hit  = (state == S_IDLE) && in_range(rd_b_addr) && valid[rd_b_addr];

    // Control FSM, valid bits and occupancy.
    // NOTE: sequential state uses non-blocking assignments only, so every read of
    // valid/mem in this cycle sees the pre-edge value (this is what makes reads read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            clr_ptr   <= '0;
            busy      <= 1'b0;
            valid     <= '0;
            occupancy <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_go) begin
                        state     <= S_CLEAR;
                        clr_ptr   <= '0;
                        busy      <= 1'b1;
                        occupancy <= '0;
                    end else if (wr_accept) begin
                        valid[wr_addr] <= 1'b1;
                        if (!valid[wr_addr]) begin
                            occupancy <= occupancy + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    valid[clr_ptr] <= 1'b0;
                    if (clr_ptr == ADDR_WIDTH'(COUNT - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale contents are hidden by the valid bits,
    // which keeps this a plain RAM-style block.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem_data[clr_ptr] <= '0;
            mem_fit[clr_ptr]  <= '0;
        end else if (wr_accept) begin
            mem_data[wr_addr] <= wr_data;
            mem_fit[wr_addr]  <= wr_fit;
        end
    end

    // Read port A: one-cycle strobe, payload held until the next read or clear start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_vld  <= 1'b0;
            rd_a_ok   <= 1'b0;
            rd_a_data <= '0;
            rd_a_fit  <= '0;
        end else begin
            rd_a_vld <= rd_a_en;
            if (rd_a_en) begin
                rd_a_ok   <= rd_a_hit;
                rd_a_data <= rd_a_hit ? mem_data[rd_a_addr] : '0;
                rd_a_fit  <= rd_a_hit ? mem_fit[rd_a_addr]  : '0;
            end else if (clr_go) begin
                rd_a_ok   <= 1'b0;
                rd_a_data <= '0;
                rd_a_fit  <= '0;
            end
        end
    end

    // Read port B: identical to port A, fully independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_b_vld  <= 1'b0;
            rd_b_ok   <= 1'b0;
            rd_b_data <= '0;
            rd_b_fit  <= '0;
        end else begin
            rd_b_vld <= rd_b_en;
            if (rd_b_en) begin
                rd_b_ok   <= rd_b_hit;
                rd_b_data <= rd_b_hit ? mem_data[rd_b_addr] : '0;
                rd_b_fit  <= rd_b_hit ? mem_fit[rd_b_addr]  : '0;
            end else if (clr_go) begin
                rd_b_ok   <= 1'b0;
                rd_b_data <= '0;
                rd_b_fit  <= '0;
            end
        end
    end

`ifdef CHROMOSOME_POOL_BEST_TRACK_EN
    // Elite register: strict greater-than keeps the earliest entry on ties and is
    // independent of later overwrites of the source entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid <= 1'b0;
            best_data  <= '0;
            best_fit   <= '0;
        end else if (clr_go) begin
            best_valid <= 1'b0;
            best_data  <= '0;
            best_fit   <= '0;
        end else if (wr_accept && (!best_valid || (wr_fit > best_fit))) begin
            best_valid <= 1'b1;
            best_data  <= wr_data;
            best_fit   <= wr_fit;
        end
    end
`else
    assign best_valid = 1'b0;
    assign best_data  = '0;
    assign best_fit   = '0;
`endif

endmodule

// File: tb/tb_chromosome_pool.sv
// Directed self-checking bench for chromosome_pool (COUNT=32), hand-computed expectations;
// elite checks follow CHROMOSOME_POOL_BEST_TRACK_EN.
module tb_chromosome_pool;

    localparam int COUNT = 32;
    localparam int DW    = 19;
    localparam int FW    = 64;
    localparam int AW    = 5;
    localparam int OW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [FW-1:0] wr_fit;
    logic          rd_a_en, rd_b_en;
    logic [AW-1:0] rd_a_addr, rd_b_addr;
    logic [DW-1:0] rd_a_data, rd_b_data;
    logic [FW-1:0] rd_a_fit, rd_b_fit;
    logic          rd_a_ok, rd_b_ok, rd_a_vld, rd_b_vld;
    logic          clr_start;
    logic          busy;
    logic [OW-1:0] occupancy;
    logic [DW-1:0] best_data;
    logic [FW-1:0] best_fit;
    logic          best_valid;

    int n_vec  = 0;
    int n_miss = 0;
    int n_busy;

`ifdef CHROMOSOME_POOL_BEST_TRACK_EN
    localparam bit ELITE = 1'b1;
`else
    localparam bit ELITE = 1'b0;
`endif

    chromosome_pool #(.COUNT(COUNT), .DATA_WIDTH(DW), .FIT_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fit(wr_fit),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_a_fit(rd_a_fit), .rd_a_ok(rd_a_ok), .rd_a_vld(rd_a_vld),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .rd_b_fit(rd_b_fit), .rd_b_ok(rd_b_ok), .rd_b_vld(rd_b_vld),
        .clr_start(clr_start), .busy(busy), .occupancy(occupancy),
        .best_data(best_data), .best_fit(best_fit), .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_en = 1'b0; rd_a_en = 1'b0; rd_b_en = 1'b0; clr_start = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [FW-1:0] f);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_fit = f;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rd_a_en = 1'b1; rd_a_addr = a; rd_b_en = 1'b1; rd_b_addr = b;
        tick();
        rd_a_en = 1'b0; rd_b_en = 1'b0;
    endtask

    task automatic check_elite(input string tag, input logic v, input logic [DW-1:0] d, input logic [FW-1:0] f);
        check({tag, "_bv"}, 64'(best_valid), ELITE ? 64'(v) : 64'd0);
        check({tag, "_bd"}, 64'(best_data),  ELITE ? 64'(d) : 64'd0);
        check({tag, "_bf"}, best_fit,        ELITE ? f      : 64'd0);
    endtask

    initial begin
        quiet();
        wr_addr = '0; wr_data = '0; wr_fit = '0; rd_a_addr = '0; rd_b_addr = '0;
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        tick();
        check("rst_occ", 64'(occupancy), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_vld", 64'(rd_a_vld), 0);
        check_elite("rst", 1'b0, '0, '0);

        // Read of an empty entry.
        rd_a_en = 1'b1; rd_a_addr = 5; tick(); rd_a_en = 1'b0;
        check("empty_vld", 64'(rd_a_vld), 1);
        check("empty_ok", 64'(rd_a_ok), 0);
        check("empty_data", 64'(rd_a_data), 0);
        check("empty_fit", rd_a_fit, 0);
        tick();
        check("vld_one_cycle", 64'(rd_a_vld), 0);

        // First write, dual-port read of the same address.
        do_write(3, 19'h1ABCD, 100);
        check("w3_occ", 64'(occupancy), 1);
        check_elite("w3", 1'b1, 19'h1ABCD, 100);
        do_read(3, 3);
        check("dual_a_ok", 64'(rd_a_ok), 1);
        check("dual_a_data", 64'(rd_a_data), 64'h1ABCD);
        check("dual_a_fit", rd_a_fit, 100);
        check("dual_b_vld", 64'(rd_b_vld), 1);
        check("dual_b_ok", 64'(rd_b_ok), 1);
        check("dual_b_data", 64'(rd_b_data), 64'h1ABCD);
        check("dual_b_fit", rd_b_fit, 100);

        // Overwrite and elite update: lower, tie, higher.
        do_write(3, 19'h00111, 50);
        check("ow_occ", 64'(occupancy), 1);
        check_elite("ow", 1'b1, 19'h1ABCD, 100);
        do_write(7, 19'h07777, 100);
        check_elite("tie", 1'b1, 19'h1ABCD, 100);
        do_write(9, 19'h09999, 200);
        check("w9_occ", 64'(occupancy), 3);
        check_elite("w9", 1'b1, 19'h09999, 200);

        // Read-first on an empty entry, then on a valid entry.
        wr_en = 1'b1; wr_addr = 4; wr_data = 19'h44444; wr_fit = 44;
        rd_a_en = 1'b1; rd_a_addr = 4;
        rd_b_en = 1'b1; rd_b_addr = 3;
        tick(); quiet();
        check("rf_a_ok", 64'(rd_a_ok), 0);
        check("rf_a_data", 64'(rd_a_data), 0);
        check("rf_b_data", 64'(rd_b_data), 64'h00111);
        check("rf_occ", 64'(occupancy), 4);
        wr_en = 1'b1; wr_addr = 9; wr_data = 19'h0AAAA; wr_fit = 10;
        rd_b_en = 1'b1; rd_b_addr = 9;
        rd_a_en = 1'b1; rd_a_addr = 4;
        tick(); quiet();
        check("rf_new_a_ok", 64'(rd_a_ok), 1);
        check("rf_new_a_data", 64'(rd_a_data), 64'h44444);
        check("rf_new_a_fit", rd_a_fit, 44);
        check("rf_old_b_data", 64'(rd_b_data), 64'h09999);
        check("rf_old_b_fit", rd_b_fit, 200);
        check("rf_ow_occ", 64'(occupancy), 4);
        check_elite("persist", 1'b1, 19'h09999, 200);
        do_read(9, 7);
        check("ow9_data", 64'(rd_a_data), 64'h0AAAA);
        check("r7_fit", rd_b_fit, 100);

        // Clear sweep: busy length, dropped write, masked read.
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        check("clr_busy", 64'(busy), 1);
        check("clr_occ", 64'(occupancy), 0);
        check("clr_rd_held_ok", 64'(rd_a_ok), 0);
        check("clr_rd_held_data", 64'(rd_a_data), 0);
        check_elite("clr", 1'b0, '0, '0);
        n_busy = 1;
        for (int i = 0; i < 100 && busy; i++) begin
            wr_en = (i == 2); wr_addr = 1; wr_data = 19'h11111; wr_fit = 999;
            rd_a_en = (i == 3); rd_a_addr = 9;
            clr_start = (i == 4);
            tick(); quiet();
            if (i == 3) begin
                check("sweep_rd_vld", 64'(rd_a_vld), 1);
                check("sweep_rd_ok", 64'(rd_a_ok), 0);
                check("sweep_rd_data", 64'(rd_a_data), 0);
            end
            if (busy) n_busy++;
        end
        check("busy_cycles", 64'(n_busy), COUNT);
        check("busy_low", 64'(busy), 0);
        do_write(2, 19'h22222, 7);
        check("post_clr_occ", 64'(occupancy), 1);
        check_elite("post_clr", 1'b1, 19'h22222, 7);
        do_read(1, 2);
        check("dropped_ok", 64'(rd_a_ok), 0);
        check("post_clr_b_ok", 64'(rd_b_ok), 1);
        check("post_clr_b_fit", rd_b_fit, 7);
        do_read(9, 4);
        check("swept9_ok", 64'(rd_a_ok), 0);
        check("swept4_data", 64'(rd_b_data), 0);

        // Reset in the middle of a sweep.
        do_write(5, 19'h55555, 5);
        do_read(5, 2);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy_pre", 64'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_occ", 64'(occupancy), 0);
        check("mid_rst_b_fit", rd_b_fit, 0);
        check_elite("mid_rst", 1'b0, '0, '0);
        #2 rst_n = 1'b1;
        do_write(0, 19'h12345, 9);
        check("after_rst_occ", 64'(occupancy), 1);
        do_read(0, 5);
        check("after_rst_a_ok", 64'(rd_a_ok), 1);
        check("after_rst_a_data", 64'(rd_a_data), 64'h12345);
        check("after_rst_b_ok", 64'(rd_b_ok), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
